// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus read-return path.
//   rx_entry_t : one buffered read beat {error, last, data}
//   rx_state_t : read-return controller states
package hyperbus_pkg;

    localparam int unsigned PHY_DATA_W = 16;

    typedef struct packed {
        logic                  error;
        logic                  last;
        logic [PHY_DATA_W-1:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ      = 2'd1,
        DRAIN_ERR = 2'd2
    } rx_state_t;

endpackage

// File: rtl/hyperbus_rx_fifo.sv
// Small synchronous FIFO buffering read beats between the PHY and the front end.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write an entry (accepted when not full, or when full and popping)
//   pop_i         : remove the head entry (ignored when empty)
//   data_o        : head entry (combinational read)
//   full_o/empty_o: occupancy flags
module hyperbus_rx_fifo
    import hyperbus_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = rx_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    entry_t        mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees the slot in the same cycle, so a full FIFO may still accept a push.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wptr_d = do_push ? wptr_q + PW'(1) : wptr_q;
    assign rptr_d = do_pop  ? rptr_q + PW'(1) : rptr_q;

    assign data_o = mem_q[rptr_q[AW-1:0]];

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/hyperbus_rx_burst_ctrl.sv
// Read-return stage between the HyperBus PHY and the AXI front end.
// Tracks the single outstanding transaction, buffers PHY read words and, on
// PHY error, buffer overflow or timeout, completes the burst with error beats
// so the front end always receives exactly the requested number of beats.
// Ports:
//   clk_i, rst_ni                     : clock, asynchronous active-low reset
//   trans_valid_i/trans_ready_o       : request from the front end (gated)
//   trans_write_i, trans_burst_i      : request direction and length in words (0 -> 1)
//   trans_valid_o/trans_ready_i       : request forwarded to the PHY
//   phy_data_i/phy_valid_i/phy_error_i: unstallable PHY read word stream
//   rx_data_o/rx_last_o/rx_error_o    : beat payload (FIFO head)
//   rx_valid_o/rx_ready_i             : beat handshake to the front end
//   busy_o                            : a read is outstanding or beats remain buffered
module hyperbus_rx_burst_ctrl
    import hyperbus_pkg::*;
#(
    parameter int unsigned BURST_WIDTH    = 12,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   trans_valid_i,
    output logic                   trans_ready_o,
    input  logic                   trans_write_i,
    input  logic [BURST_WIDTH-1:0] trans_burst_i,
    output logic                   trans_valid_o,
    input  logic                   trans_ready_i,
    input  logic [15:0]            phy_data_i,
    input  logic                   phy_valid_i,
    input  logic                   phy_error_i,
    output logic [15:0]            rx_data_o,
    output logic                   rx_last_o,
    output logic                   rx_error_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic                   busy_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    rx_state_t              state_q, state_d;
    logic [BURST_WIDTH-1:0] rem_q, rem_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;

    logic      fifo_push;
    rx_entry_t fifo_wdata;
    rx_entry_t fifo_head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_pop;
    logic      can_push;
    logic      handshake;
    logic      rem_is_one;

    // Requests pass only when fully idle: no read tracked and no beats left.
    assign trans_valid_o = trans_valid_i & (state_q == IDLE) & fifo_empty;
    assign trans_ready_o = trans_ready_i & trans_valid_o;
    assign handshake     = trans_valid_o & trans_ready_i;

    assign fifo_pop   = ~fifo_empty & rx_ready_i;
    assign can_push   = ~fifo_full | fifo_pop;
    assign rem_is_one = (rem_q == BURST_WIDTH'(1));

    // Next-state, burst counter, timeout counter and FIFO write.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        tmo_d      = tmo_q;
        fifo_push  = 1'b0;
        fifo_wdata = '0;

        case (state_q)
            IDLE: begin
                if (handshake && !trans_write_i) begin
                    rem_d   = (trans_burst_i == '0) ? BURST_WIDTH'(1) : trans_burst_i;
                    tmo_d   = '0;
                    state_d = READ;
                end
            end

            READ: begin
                if (phy_valid_i) begin
                    tmo_d = '0;
                    if (can_push) begin
                        fifo_push        = 1'b1;
                        fifo_wdata.error = phy_error_i;
                        fifo_wdata.last  = rem_is_one;
                        fifo_wdata.data  = phy_data_i;
                        rem_d            = rem_q - BURST_WIDTH'(1);
                        if (rem_is_one) begin
                            state_d = IDLE;
                        end else if (phy_error_i) begin
                            state_d = DRAIN_ERR;
                        end
                    end else begin
                        // Overflow: word is lost, the rest of the burst becomes error beats.
                        state_d = DRAIN_ERR;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = DRAIN_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            DRAIN_ERR: begin
                // Synthesise the outstanding beats; late PHY words are ignored.
                if (can_push) begin
                    fifo_push        = 1'b1;
                    fifo_wdata.error = 1'b1;
                    fifo_wdata.last  = rem_is_one;
                    fifo_wdata.data  = 16'h0000;
                    rem_d            = rem_q - BURST_WIDTH'(1);
                    if (rem_is_one) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rem_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
        end
    end

    hyperbus_rx_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (rx_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head fields are forced to zero while nothing is buffered.
    assign rx_valid_o = ~fifo_empty;
    assign rx_data_o  = fifo_empty ? 16'h0000 : fifo_head.data;
    assign rx_last_o  = ~fifo_empty & fifo_head.last;
    assign rx_error_o = ~fifo_empty & fifo_head.error;
    assign busy_o     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: doc/hyperbus_rx_burst_ctrl.md
Name: hyperbus_rx_burst_ctrl

Overview:
Read-return stage between the HyperBus PHY and the AXI front end. It tracks the single outstanding transaction and buffers PHY read words in a small FIFO. It produces the rx_data/rx_last/rx_error/rx_valid stream the front end consumes. On PHY error, FIFO overflow or timeout it supplies the remaining AXI beats as error beats, so the front end always receives exactly trans_burst beats.

Parameters:
BURST_WIDTH, 12, width of the burst length in 16-bit words.
FIFO_DEPTH, 8, read buffer entries; power of two, at least 2.
TIMEOUT_CYCLES, 1024, idle cycles allowed between PHY read words before abort; at least 2.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
trans_valid_i  in  1  transaction request from the front end
trans_ready_o  out  1  request accepted; passed through to the PHY, gated
trans_write_i  in  1  1 = write, 0 = read
trans_burst_i  in  BURST_WIDTH  number of 16-bit words; 0 is treated as 1
trans_valid_o  out  1  request forwarded to the PHY
trans_ready_i  in  1  PHY accepts the request
phy_data_i  in  16  read word from the PHY
phy_valid_i  in  1  read word valid; the PHY cannot be stalled
phy_error_i  in  1  qualifies phy_valid_i; the word is erroneous
rx_data_o  out  16  read data to the front end
rx_last_o  out  1  final beat of the burst
rx_error_o  out  1  beat carries an error
rx_valid_o  out  1  beat valid
rx_ready_i  in  1  front end accepts the beat
busy_o  out  1  read outstanding (state other than IDLE, or FIFO not empty)

Behaviour:
- Reset: state IDLE, FIFO empty, counters 0. All outputs 0 except rx_data_o, which is 0 while the FIFO is empty.
- Request gating:
  - trans_valid_o = trans_valid_i while state is IDLE and the FIFO is empty; otherwise 0.
  - trans_ready_o = trans_ready_i & trans_valid_o (combinational).
  - Handshake = trans_valid_o & trans_ready_i.
- States: IDLE, READ, DRAIN_ERR.
- IDLE:
  - On a handshake with trans_write_i = 0: load remaining = max(trans_burst_i, 1), clear the timeout counter, go to READ.
  - On a write handshake: stay in IDLE; the write data path is not involved.
- READ:
  - If phy_valid_i and the FIFO is not full: push {error = phy_error_i, last = (remaining == 1), data}, then decrement remaining.
  - If remaining == 1 on the push and the word has no error, go to IDLE.
  - If phy_error_i (with phy_valid_i): push that word with error = 1. If remaining > 1, go to DRAIN_ERR with remaining decremented; otherwise go to IDLE.
  - If phy_valid_i and the FIFO is full (overflow): drop the word and go to DRAIN_ERR; remaining is unchanged.
  - Timeout counter increments on each cycle without phy_valid_i and clears on phy_valid_i. When it reaches TIMEOUT_CYCLES-1, go to DRAIN_ERR.
- DRAIN_ERR:
  - phy_valid_i is ignored.
  - Whenever the FIFO is not full, push {error = 1, last = (remaining == 1), data = 16'h0000} and decrement remaining.
  - The push with remaining == 1 returns the state to IDLE.
- Output side:
  - rx_valid_o = FIFO not empty; rx_data_o, rx_last_o and rx_error_o come from the FIFO head.
  - Pop on rx_valid_o & rx_ready_i.
  - Push and pop in the same cycle are both allowed, including when the FIFO is full, since the pop frees the slot in that cycle.
- Latency: a PHY word appears on rx_valid_o one cycle after phy_valid_i (registered FIFO write, combinational read of the head).
- Exactly one read is outstanding. A new request is accepted only after IDLE is reached and the FIFO has fully drained, so rx_last_o is never followed by beats of the same burst.
- Widths: remaining is BURST_WIDTH bits. The timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates.
- Reset mid-burst: all state is discarded immediately and no rx beats are produced afterwards.

Decomposition:
- hyperbus_pkg holds:
  - the typedef rx_entry_t (packed struct {error, last, data[15:0]});
  - the enum rx_state_t {IDLE, READ, DRAIN_ERR}.
- Sub-module hyperbus_rx_fifo, parameterised by DEPTH and entry type:
  - synchronous push and pop, full and empty flags;
  - simultaneous push and pop allowed when full.
- Top level: the FSM, burst counter and timeout counter.

Test Plan:
- Read with burst 4, PHY words 0x1111..0x4444 back-to-back, rx_ready_i = 1 -> four beats one cycle behind the PHY; last only on 0x4444; error = 0; busy_o low after the pop.
- Read with burst 12, FIFO_DEPTH 8, rx_ready_i = 0 for 20 cycles -> the 9th PHY word overflows; beats 1-8 are good data; 4 error beats with data 0 follow; last on beat 12.
- Read with burst 3, phy_error_i on word 2 -> beat 1 good; beat 2 error; beat 3 synthesised error with last = 1; PHY word 3 ignored.
- Read with burst 2, only 1 PHY word, then silence -> after TIMEOUT_CYCLES idle cycles, beat 2 is an error beat with last = 1; state returns to IDLE.
- Back-to-back requests with trans_valid_i held high -> second trans_ready_o only after the first burst's last beat is popped; a write request with burst 0 is forwarded with no rx beats.
- rst_ni asserted mid-burst (after 2 of 4 words) -> rx_valid_o = 0 immediately; after release, a new burst-1 read returns a single beat with last = 1.
